// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL lock sequencer: state encoding and counter sizing.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    StResetPll = 3'd0,
    StWaitLock = 3'd1,
    StFilter   = 3'd2,
    StRelease  = 3'd3,
    StRun      = 3'd4
  } pll_state_e;

  // Bits needed to hold values 0..max_val (never less than one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level signal.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: pulses the PLL reset, filters lock, then releases channel
// resets in ascending order, and restarts the whole sequence on lock loss or timeout.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned RST_PULSE = 16,
  parameter int unsigned LOCK_FILT = 1024,
  parameter int unsigned STAGE_GAP = 64,
  parameter int unsigned TIMEOUT   = 65536,
  parameter int unsigned CNT_W     = 8
) (
  input  logic              clkin,
  input  logic              reset,
  input  logic              lock,
  output logic              pll_reset,
  output logic [N_CH-1:0]   ch_rst,
  output logic              all_ready,
  output logic [CNT_W-1:0]  loss_cnt,
  output logic [CNT_W-1:0]  to_cnt,
  output logic [2:0]        state_o
);

  localparam int unsigned RCW = cnt_width(RST_PULSE - 1);
  localparam int unsigned TCW = cnt_width(TIMEOUT - 1);
  localparam int unsigned FCW = cnt_width(LOCK_FILT - 1);
  localparam int unsigned SCW = cnt_width(STAGE_GAP - 1);

  localparam logic [RCW-1:0]   RST_LAST  = RCW'(RST_PULSE - 1);
  localparam logic [TCW-1:0]   TO_LAST   = TCW'(TIMEOUT - 1);
  localparam logic [FCW-1:0]   FILT_LAST = FCW'(LOCK_FILT - 1);
  localparam logic [SCW-1:0]   GAP_LAST  = SCW'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic lock_s;

  pll_state_e       state_q, state_d;
  logic [RCW-1:0]   rcnt_q, rcnt_d;
  logic [TCW-1:0]   tcnt_q, tcnt_d;
  logic [FCW-1:0]   fcnt_q, fcnt_d;
  logic [SCW-1:0]   scnt_q, scnt_d;
  logic             pll_reset_q, pll_reset_d;
  logic [N_CH-1:0]  ch_rst_q, ch_rst_d;
  logic             all_ready_q, all_ready_d;
  logic [CNT_W-1:0] loss_cnt_q, loss_cnt_d;
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;

  logic step_release;
  logic enter_reset;
  logic lost;

  sync_2ff u_lock_sync (
    .clk_i (clkin),
    .rst_i (reset),
    .d_i   (lock),
    .q_o   (lock_s)
  );

  always_comb begin
    state_d      = state_q;
    rcnt_d       = rcnt_q;
    tcnt_d       = tcnt_q;
    fcnt_d       = fcnt_q;
    scnt_d       = scnt_q;
    pll_reset_d  = pll_reset_q;
    ch_rst_d     = ch_rst_q;
    all_ready_d  = all_ready_q;
    loss_cnt_d   = loss_cnt_q;
    to_cnt_d     = to_cnt_q;
    step_release = 1'b0;
    enter_reset  = 1'b0;
    lost         = 1'b0;

    unique case (state_q)
      StResetPll: begin
        if (rcnt_q == RST_LAST) begin
          state_d     = StWaitLock;
          pll_reset_d = 1'b0;
          tcnt_d      = '0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      StWaitLock: begin
        // The WAIT_LOCK cycle that first sees lock counts as the first filtered cycle.
        if (lock_s) begin
          if (LOCK_FILT == 1) begin
            step_release = 1'b1;
          end else begin
            state_d = StFilter;
            fcnt_d  = FCW'(1);
          end
        end else if (tcnt_q == TO_LAST) begin
          enter_reset = 1'b1;
          if (to_cnt_q != CNT_MAX) to_cnt_d = to_cnt_q + 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      StFilter: begin
        if (!lock_s) begin
          state_d = StWaitLock;
          tcnt_d  = '0;
        end else if (fcnt_q == FILT_LAST) begin
          step_release = 1'b1;
        end else begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end
      StRelease: begin
        if (!lock_s) begin
          lost = 1'b1;
        end else if (scnt_q == GAP_LAST) begin
          step_release = 1'b1;
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      StRun: begin
        if (!lock_s) lost = 1'b1;
      end
      default: enter_reset = 1'b1;
    endcase

    // Shifting in zeros from bit 0 keeps releases strictly ascending.
    if (step_release) begin
      ch_rst_d = ch_rst_q << 1;
      scnt_d   = '0;
      if (ch_rst_d == '0) begin
        state_d     = StRun;
        all_ready_d = 1'b1;
      end else begin
        state_d = StRelease;
      end
    end

    if (lost) begin
      enter_reset = 1'b1;
      if (loss_cnt_q != CNT_MAX) loss_cnt_d = loss_cnt_q + 1'b1;
    end

    if (enter_reset) begin
      state_d     = StResetPll;
      rcnt_d      = '0;
      pll_reset_d = 1'b1;
      ch_rst_d    = '1;
      all_ready_d = 1'b0;
    end
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q     <= StResetPll;
      rcnt_q      <= '0;
      tcnt_q      <= '0;
      fcnt_q      <= '0;
      scnt_q      <= '0;
      pll_reset_q <= 1'b1;
      ch_rst_q    <= '1;
      all_ready_q <= 1'b0;
      loss_cnt_q  <= '0;
      to_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      rcnt_q      <= rcnt_d;
      tcnt_q      <= tcnt_d;
      fcnt_q      <= fcnt_d;
      scnt_q      <= scnt_d;
      pll_reset_q <= pll_reset_d;
      ch_rst_q    <= ch_rst_d;
      all_ready_q <= all_ready_d;
      loss_cnt_q  <= loss_cnt_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  assign pll_reset = pll_reset_q;
  assign ch_rst    = ch_rst_q;
  assign all_ready = all_ready_q;
  assign loss_cnt  = loss_cnt_q;
  assign to_cnt    = to_cnt_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed timing scenarios plus random lock traffic,
// all checked cycle by cycle against a timestamp-based reference model.
module tb_pll_lock_sequencer;

  localparam int N_CH      = 4;
  localparam int RST_PULSE = 4;
  localparam int LOCK_FILT = 8;
  localparam int STAGE_GAP = 3;
  localparam int TIMEOUT   = 100;
  localparam int CNT_W     = 4;
  localparam int CMAX      = (1 << CNT_W) - 1;
  localparam int VW        = 1 + N_CH + 1 + 2 * CNT_W + 3;

  logic             clkin = 1'b0;
  logic             reset = 1'b1;
  logic             lock  = 1'b0;
  logic             pll_reset;
  logic [N_CH-1:0]  ch_rst;
  logic             all_ready;
  logic [CNT_W-1:0] loss_cnt;
  logic [CNT_W-1:0] to_cnt;
  logic [2:0]       state_o;

  pll_lock_sequencer #(
    .N_CH      (N_CH),
    .RST_PULSE (RST_PULSE),
    .LOCK_FILT (LOCK_FILT),
    .STAGE_GAP (STAGE_GAP),
    .TIMEOUT   (TIMEOUT),
    .CNT_W     (CNT_W)
  ) dut (
    .clkin     (clkin),
    .reset     (reset),
    .lock      (lock),
    .pll_reset (pll_reset),
    .ch_rst    (ch_rst),
    .all_ready (all_ready),
    .loss_cnt  (loss_cnt),
    .to_cnt    (to_cnt),
    .state_o   (state_o)
  );

  always #5 clkin = ~clkin;

  int n_vec = 0;
  int n_mis = 0;

  // Model: cycle t counts from the first cycle after reset; phases are timestamps (-1 = inactive).
  int t;
  bit lock_hist[$];
  int pulse_start, wait_start, streak_start, rel_start, m_loss, m_to;
  logic [VW-1:0] exp_vec;
  logic [VW-1:0] obs_vec;

  assign obs_vec = {pll_reset, ch_rst, all_ready, loss_cnt, to_cnt, state_o};

  function automatic bit ls_at(input int c);
    return (c >= 2) ? lock_hist[c-2] : 1'b0;
  endfunction

  task automatic model_init();
    lock_hist.delete();
    t = 0;
    pulse_start  = 0;
    wait_start   = -1;
    streak_start = -1;
    rel_start    = -1;
    m_loss       = 0;
    m_to         = 0;
  endtask

  task automatic model_outputs();
    logic [N_CH-1:0] m_ch;
    bit   pulse;
    bit   rdy;
    logic [2:0] st;
    pulse = (wait_start < 0) && (rel_start < 0);
    for (int k = 0; k < N_CH; k++)
      m_ch[k] = !((rel_start >= 0) && (t >= rel_start + k * STAGE_GAP));
    rdy = (rel_start >= 0) && (t >= rel_start + (N_CH - 1) * STAGE_GAP);
    if (pulse) st = 3'd0;
    else if (wait_start >= 0) st = (streak_start >= 0) ? 3'd2 : 3'd1;
    else st = rdy ? 3'd4 : 3'd3;
    exp_vec = {pulse, m_ch, rdy, CNT_W'(m_loss), CNT_W'(m_to), st};
  endtask

  task automatic model_step(input bit s);
    if (rel_start >= 0) begin
      if (!s) begin
        if (m_loss < CMAX) m_loss++;
        rel_start   = -1;
        pulse_start = t + 1;
      end
    end else if (wait_start >= 0) begin
      if (s) begin
        if (streak_start < 0) streak_start = t;
        if (t - streak_start + 1 == LOCK_FILT) begin
          rel_start    = t + 1;
          wait_start   = -1;
          streak_start = -1;
        end
      end else if (streak_start >= 0) begin
        streak_start = -1;
        wait_start   = t + 1;
      end else if (t - wait_start + 1 == TIMEOUT) begin
        if (m_to < CMAX) m_to++;
        wait_start  = -1;
        pulse_start = t + 1;
      end
    end else if (t - pulse_start + 1 == RST_PULSE) begin
      wait_start = t + 1;
    end
  endtask

  // Drive lock for the current cycle, advance one clock, refresh expectations.
  task automatic tick(input bit l);
    lock = l;
    lock_hist.push_back(l);
    model_step(ls_at(t));
    @(posedge clkin);
    #1;
    t++;
    model_outputs();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clkin);
    #1;
    reset = 1'b0;
    model_init();
    model_outputs();
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++;
    if (pll_reset !== 1'b1 || ch_rst !== 4'hF || all_ready !== 1'b0 || loss_cnt !== 4'd0 ||
        to_cnt !== 4'd0 || state_o !== 3'd0) begin
      n_mis++;
      $display("FAIL reset_state: dut=%h required=%h", obs_vec, {1'b1, 4'hF, 1'b0, 8'h00, 3'd0});
    end
    n_vec++;
    if (obs_vec !== exp_vec) begin
      n_mis++;
      $display("FAIL reset_model: dut=%h model=%h", obs_vec, exp_vec);
    end
  endtask

  task automatic test_lock_sequence();
    int fall[N_CH];
    int ready_at = -1;
    int pll_hi   = 0;
    for (int k = 0; k < N_CH; k++) fall[k] = -1;
    apply_reset();
    for (int i = 0; i < 45; i++) begin
      n_vec++;
      if (obs_vec !== exp_vec) begin
        n_mis++;
        $display("FAIL lock_seq cycle %0d: dut=%h model=%h", t, obs_vec, exp_vec);
      end
      for (int k = 0; k < N_CH; k++) if (fall[k] < 0 && ch_rst[k] === 1'b0) fall[k] = t;
      if (ready_at < 0 && all_ready === 1'b1) ready_at = t;
      if (pll_reset === 1'b1) pll_hi++;
      tick(t >= 10);
    end
    for (int k = 0; k < N_CH; k++) begin
      n_vec++;
      if (fall[k] != 20 + 3 * k) begin
        n_mis++;
        $display("FAIL lock_seq_fall%0d: fell at %0d, required %0d", k, fall[k], 20 + 3 * k);
      end
    end
    n_vec++;
    if (ready_at != 29 || pll_hi != 4) begin
      n_mis++;
      $display("FAIL lock_seq_ready: ready at %0d pll_reset cycles %0d, required 29 and 4",
               ready_at, pll_hi);
    end
  endtask

  task automatic test_lock_glitch();
    int fall0 = -1;
    apply_reset();
    for (int i = 0; i < 35; i++) begin
      n_vec++;
      if (obs_vec !== exp_vec) begin
        n_mis++;
        $display("FAIL glitch cycle %0d: dut=%h model=%h", t, obs_vec, exp_vec);
      end
      if (fall0 < 0 && ch_rst[0] === 1'b0) fall0 = t;
      tick((t >= 10) && (t != 15));
    end
    n_vec++;
    if (fall0 != 26) begin
      n_mis++;
      $display("FAIL glitch_fall0: fell at %0d, required 26", fall0);
    end
  endtask

  task automatic test_timeout();
    int   rises[3];
    int   n_rise = 0;
    logic prev   = 1'b1;
    apply_reset();
    for (int i = 0; i < 320; i++) begin
      n_vec++;
      if (obs_vec !== exp_vec) begin
        n_mis++;
        $display("FAIL timeout cycle %0d: dut=%h model=%h", t, obs_vec, exp_vec);
      end
      if (pll_reset === 1'b1 && prev === 1'b0 && n_rise < 3) begin
        rises[n_rise] = t;
        n_rise++;
      end
      prev = pll_reset;
      tick(1'b0);
    end
    n_vec++;
    if (n_rise != 3 || rises[0] != 104 || rises[1] != 208 || rises[2] != 312) begin
      n_mis++;
      $display("FAIL timeout_repulse: %0d rises (first %0d), required 3 at 104/208/312",
               n_rise, rises[0]);
    end
    n_vec++;
    if (to_cnt !== 4'd3) begin
      n_mis++;
      $display("FAIL timeout_count: to_cnt=%0d required 3", to_cnt);
    end
  endtask

  task automatic test_lock_loss();
    apply_reset();
    for (int i = 0; i < 50; i++) begin
      n_vec++;
      if (obs_vec !== exp_vec) begin
        n_mis++;
        $display("FAIL loss cycle %0d: dut=%h model=%h", t, obs_vec, exp_vec);
      end
      if (t == 42) begin
        n_vec++;
        if (all_ready !== 1'b1 || ch_rst !== 4'h0) begin
          n_mis++;
          $display("FAIL loss_before: all_ready=%b ch_rst=%b required 1 and 0000", all_ready, ch_rst);
        end
      end
      if (t == 43) begin
        n_vec++;
        if (ch_rst !== 4'hF || all_ready !== 1'b0 || pll_reset !== 1'b1 || loss_cnt !== 4'd1) begin
          n_mis++;
          $display("FAIL loss_after: ch_rst=%b all_ready=%b pll_reset=%b loss_cnt=%0d required 1111 0 1 1",
                   ch_rst, all_ready, pll_reset, loss_cnt);
        end
      end
      tick(t < 40);
    end
  endtask

  task automatic test_loss_saturation();
    apply_reset();
    for (int n = 0; n < 20; n++) begin
      int budget = 0;
      while (all_ready !== 1'b1 && budget < 80) begin
        n_vec++;
        if (obs_vec !== exp_vec) begin
          n_mis++;
          $display("FAIL saturation cycle %0d: dut=%h model=%h", t, obs_vec, exp_vec);
        end
        tick(1'b1);
        budget++;
      end
      if (budget >= 80) begin
        n_vec++;
        n_mis++;
        $display("FAIL saturation_wait: all_ready=%b after %0d cycles, required 1", all_ready, budget);
      end
      for (int j = 0; j < 5; j++) begin
        n_vec++;
        if (obs_vec !== exp_vec) begin
          n_mis++;
          $display("FAIL saturation cycle %0d: dut=%h model=%h", t, obs_vec, exp_vec);
        end
        tick(j != 1);
      end
    end
    for (int i = 0; i < 10; i++) begin
      n_vec++;
      if (obs_vec !== exp_vec) begin
        n_mis++;
        $display("FAIL saturation cycle %0d: dut=%h model=%h", t, obs_vec, exp_vec);
      end
      tick(1'b1);
    end
    n_vec++;
    if (loss_cnt !== 4'd15) begin
      n_mis++;
      $display("FAIL saturation_value: loss_cnt=%0d required 15", loss_cnt);
    end
  endtask

  task automatic test_reset_mid_release();
    int budget = 0;
    while (ch_rst !== 4'b1100 && budget < 80) begin
      n_vec++;
      if (obs_vec !== exp_vec) begin
        n_mis++;
        $display("FAIL mid_release cycle %0d: dut=%h model=%h", t, obs_vec, exp_vec);
      end
      tick(1'b1);
      budget++;
    end
    n_vec++;
    if (ch_rst !== 4'b1100 || loss_cnt === 4'd0) begin
      n_mis++;
      $display("FAIL mid_release_reach: ch_rst=%b loss_cnt=%0d, required 1100 and nonzero",
               ch_rst, loss_cnt);
    end
    lock = 1'b1;
    apply_reset();
    n_vec++;
    if (ch_rst !== 4'hF || loss_cnt !== 4'd0 || to_cnt !== 4'd0 || state_o !== 3'd0 ||
        pll_reset !== 1'b1 || all_ready !== 1'b0) begin
      n_mis++;
      $display("FAIL mid_release_reset: dut=%h required=%h", obs_vec, {1'b1, 4'hF, 1'b0, 8'h00, 3'd0});
    end
    for (int i = 0; i < 30; i++) begin
      n_vec++;
      if (obs_vec !== exp_vec) begin
        n_mis++;
        $display("FAIL post_reset cycle %0d: dut=%h model=%h", t, obs_vec, exp_vec);
      end
      tick(1'b1);
    end
  endtask

  task automatic test_random();
    for (int epoch = 0; epoch < 6; epoch++) begin
      bit level  = 1'($urandom_range(0, 1));
      int remain = $urandom_range(1, 20);
      apply_reset();
      for (int i = 0; i < 400; i++) begin
        n_vec++;
        if (obs_vec !== exp_vec) begin
          n_mis++;
          $display("FAIL random epoch %0d cycle %0d: dut=%h model=%h", epoch, t, obs_vec, exp_vec);
        end
        if (remain == 0) begin
          level = !level;
          if (level) remain = $urandom_range(3, 60);
          else if ($urandom_range(0, 7) == 0) remain = $urandom_range(100, 230);
          else remain = $urandom_range(1, 4);
        end
        remain--;
        tick(level);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock_sequence();
    test_lock_glitch();
    test_timeout();
    test_lock_loss();
    test_loss_saturation();
    test_reset_mid_release();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_mis);
    $fatal(1);
  end

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of downstream clock channels (1..7), one reset output each.
REQ-002 SHALL have parameter RST_PULSE, default 16: pll_reset pulse width in clkin cycles (>=1).
REQ-003 SHALL have parameter LOCK_FILT, default 1024: consecutive synchronised-lock cycles required before release (>=1).
REQ-004 SHALL have parameter STAGE_GAP, default 64: cycles between successive channel reset releases (>=1).
REQ-005 SHALL have parameter TIMEOUT, default 65536: maximum WAIT_LOCK cycles before PLL reset retry (>=1).
REQ-006 SHALL have parameter CNT_W, default 8: width of the fault counters.
REQ-007 SHALL have ports:
  clkin  in  1  single clock for the whole block; free-running PLL reference clock
  reset  in  1  synchronous active-high reset
  lock  in  1  PLL lock indication, asynchronous to clkin
  pll_reset  out  1  active-high reset to the PLL primitive
  ch_rst  out  N_CH  active-high per-channel reset; bit k serves PLL output k
  all_ready  out  1  high only in RUN
  loss_cnt  out  CNT_W  saturating count of lock losses after release began
  to_cnt  out  CNT_W  saturating count of WAIT_LOCK timeouts
  state_o  out  3  encoded current state, for debug

Function
REQ-008 SHALL synchronise lock through two flops; lock_s denotes the second flop output; no other logic uses lock directly.
REQ-009 SHALL implement states RESET_PLL, WAIT_LOCK, FILTER, RELEASE, RUN, encoded 0..4 on state_o.
REQ-010 RESET_PLL: pll_reset=1 for exactly RST_PULSE cycles, then -> WAIT_LOCK.
REQ-011 WAIT_LOCK: pll_reset=0, timeout counter increments each cycle; lock_s=1 -> FILTER; counter reaching TIMEOUT with lock_s=0 -> RESET_PLL and to_cnt increments.
REQ-012 FILTER: counts consecutive cycles with lock_s=1; any lock_s=0 -> WAIT_LOCK with timeout counter cleared; count reaching LOCK_FILT -> RELEASE.
REQ-013 RELEASE: ch_rst[0] deasserts on the first RELEASE cycle; ch_rst[k] deasserts exactly STAGE_GAP cycles after ch_rst[k-1]; on the cycle ch_rst[N_CH-1] deasserts -> RUN.
REQ-014 Consequence: ch_rst[0] falls exactly 2+LOCK_FILT cycles after lock rises (uninterrupted lock, block already in WAIT_LOCK).
REQ-015 RUN: all_ready=1, ch_rst all 0, held indefinitely while lock_s=1.
REQ-016 lock_s=0 in RELEASE or RUN: next cycle ch_rst all 1, all_ready=0, loss_cnt increments, state -> RESET_PLL.
REQ-017 loss_cnt and to_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-018 ch_rst bits SHALL only ever deassert in ascending index order and assert together.
REQ-019 All outputs SHALL be registered; no combinational path from lock to any output.
REQ-020 N_CH=1 SHALL enter RUN on the first RELEASE cycle.

Reset
REQ-021 reset=1 SHALL, at the next clkin edge regardless of state: state=RESET_PLL, pll_reset=1, ch_rst all 1, all_ready=0, loss_cnt=0, to_cnt=0, all internal counters and sync flops 0.
REQ-022 Reset asserted mid-RELEASE or mid-RUN SHALL behave identically to reset at power-up; RST_PULSE counting starts on the first cycle after reset deasserts.

Structure
REQ-023 State encoding constants and the counter-width helper function SHALL live in shared package pll_seq_pkg.
REQ-024 The two-flop synchroniser SHALL be sub-module sync_2ff, reusable elsewhere in the design.
REQ-025 Internal counter widths SHALL be derived from the parameters by the package helper; no fixed widths.

Verification (params N_CH=4, RST_PULSE=4, LOCK_FILT=8, STAGE_GAP=3, TIMEOUT=100, CNT_W=4)
REQ-026 Reset released at cycle 0, lock rises at cycle 10 and stays high -> pll_reset high cycles 0-3; ch_rst[0..3] fall at cycles 20,23,26,29; all_ready=1 from cycle 29.
REQ-027 Lock rises at 10, low for one cycle at 15, high again from 16 -> ch_rst[0] falls at cycle 26, not 20.
REQ-028 Lock held low -> pll_reset re-pulses after 100 WAIT_LOCK cycles, to_cnt=1, and again after each further 104 cycles.
REQ-029 In RUN, lock falls at cycle T -> ch_rst=4'b1111 and all_ready=0 at T+3, pll_reset=1 at T+3, loss_cnt=1.
REQ-030 20 forced lock losses -> loss_cnt=15 and stays 15.
REQ-031 reset pulsed while ch_rst=4'b1100 -> next cycle ch_rst=4'b1111, counters 0, state_o=0.
